// File: rtl/cpu_mul_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mul_writeback_if
// Brief    : Issue, hazard-query and write-back signals of the multiply unit
// Revision : 1.0
// ============================================================================
interface cpu_mul_writeback_if #(
    parameter int REG_WIDTH = 32,
    parameter int RA_W      = 5
);
    logic                 issue_valid;
    logic                 issue_ready;
    logic [RA_W-1:0]      issue_rd;
    logic [REG_WIDTH-1:0] issue_a;
    logic [REG_WIDTH-1:0] issue_b;
    logic                 flush;
    logic [RA_W-1:0]      hazard_rs_a;
    logic [RA_W-1:0]      hazard_rs_b;
    logic                 hazard_a;
    logic                 hazard_b;
    logic                 write_enable_mul;
    logic [RA_W-1:0]      write_reg_mul;
    logic [REG_WIDTH-1:0] write_data_mul;

    modport master (
        output issue_valid, issue_rd, issue_a, issue_b, flush,
               hazard_rs_a, hazard_rs_b,
        input  issue_ready, hazard_a, hazard_b,
               write_enable_mul, write_reg_mul, write_data_mul
    );

    modport slave (
        input  issue_valid, issue_rd, issue_a, issue_b, flush,
               hazard_rs_a, hazard_rs_b,
        output issue_ready, hazard_a, hazard_b,
               write_enable_mul, write_reg_mul, write_data_mul
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mul_writeback.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mul_writeback
// Brief    : Fixed-latency pipelined multiplier feeding the register file's
//            dedicated multiply write port, with a pending-write bitmap
// Revision : 1.0
// ============================================================================
module cpu_mul_writeback #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int MUL_STAGES = 4,
    parameter int RA_W       = $clog2(NUM_REGS)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    cpu_mul_writeback_if.slave bus
);
    localparam int c_HALF = REG_WIDTH / 2;

    logic [MUL_STAGES-1:0] r_valid;
    logic [RA_W-1:0]       r_rd   [MUL_STAGES];
    logic [REG_WIDTH-1:0]  r_data [MUL_STAGES];
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic                  w_accept;

    assign bus.issue_ready = !bus.flush && !r_busy[bus.issue_rd];
    assign w_accept        = bus.issue_valid && bus.issue_ready;
    assign bus.hazard_a    = r_busy[bus.hazard_rs_a];
    assign bus.hazard_b    = r_busy[bus.hazard_rs_b];

    // Invalid stages carry zeros, so the last stage drives the port directly.
    assign bus.write_enable_mul = r_valid[MUL_STAGES-1];
    assign bus.write_reg_mul    = r_rd[MUL_STAGES-1];
    assign bus.write_data_mul   = r_data[MUL_STAGES-1];

    generate
        if (MUL_STAGES == 1) begin : g_single
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_valid   <= '0;
                    r_rd[0]   <= '0;
                    r_data[0] <= '0;
                end else if (bus.flush) begin
                    r_valid   <= '0;
                    r_rd[0]   <= '0;
                    r_data[0] <= '0;
                end else begin
                    r_valid   <= w_accept;
                    r_rd[0]   <= w_accept ? bus.issue_rd : '0;
                    r_data[0] <= w_accept ? REG_WIDTH'(bus.issue_a * bus.issue_b) : '0;
                end
            end
        end else begin : g_multi
            // Split b into halves: stage 0 forms two partial products, stage 1 sums them.
            logic [REG_WIDTH-1:0] w_b_lo;
            logic [REG_WIDTH-1:0] w_b_hi;
            logic [REG_WIDTH-1:0] w_p_lo;
            logic [REG_WIDTH-1:0] w_p_hi;
            logic [REG_WIDTH-1:0] r_phi;

            assign w_b_lo = {{(REG_WIDTH-c_HALF){1'b0}}, bus.issue_b[c_HALF-1:0]};
            assign w_b_hi = {bus.issue_b[REG_WIDTH-1:c_HALF], {c_HALF{1'b0}}};
            assign w_p_lo = REG_WIDTH'(bus.issue_a * w_b_lo);
            assign w_p_hi = REG_WIDTH'(bus.issue_a * w_b_hi);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_valid <= '0;
                    r_phi   <= '0;
                    for (int k = 0; k < MUL_STAGES; k++) begin
                        r_rd[k]   <= '0;
                        r_data[k] <= '0;
                    end
                end else if (bus.flush) begin
                    r_valid <= '0;
                    r_phi   <= '0;
                    for (int k = 0; k < MUL_STAGES; k++) begin
                        r_rd[k]   <= '0;
                        r_data[k] <= '0;
                    end
                end else begin
                    r_valid   <= {r_valid[MUL_STAGES-2:0], w_accept};
                    r_rd[0]   <= w_accept ? bus.issue_rd : '0;
                    r_data[0] <= w_accept ? w_p_lo : '0;
                    r_phi     <= w_accept ? w_p_hi : '0;
                    r_rd[1]   <= r_rd[0];
                    r_data[1] <= r_data[0] + r_phi;
                    for (int k = 2; k < MUL_STAGES; k++) begin
                        r_rd[k]   <= r_rd[k-1];
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_accept)
            w_set[bus.issue_rd] = 1'b1;
        if (r_valid[MUL_STAGES-1])
            w_clr[r_rd[MUL_STAGES-1]] = 1'b1;
    end

    // Issue is blocked while a bit is set, so set and clear never hit the same bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_busy <= '0;
        else if (bus.flush)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr) | w_set;
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_mul_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mul_writeback
// Brief    : Randomized bench for the multiply write-back unit (4-stage and
//            1-stage builds) against a queue-based reference model
// Revision : 1.0
// ============================================================================
module tb_cpu_mul_writeback;
    localparam int W   = 32;
    localparam int NR  = 32;
    localparam int RAW = 5;
    localparam int S   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cpu_mul_writeback_if #(.REG_WIDTH(W), .RA_W(RAW)) bus4 ();
    cpu_mul_writeback_if #(.REG_WIDTH(W), .RA_W(RAW)) bus1 ();

    cpu_mul_writeback #(.REG_WIDTH(W), .NUM_REGS(NR), .MUL_STAGES(S), .RA_W(RAW))
        dut4 (.clock(clock), .reset(reset), .bus(bus4));
    cpu_mul_writeback #(.REG_WIDTH(W), .NUM_REGS(NR), .MUL_STAGES(1), .RA_W(RAW))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // Reference model: every accepted op is one record; it is pending from its
    // issue edge n until edge n+S, and visible on the port when edge count is n+S-1.
    typedef struct {
        int             n;
        logic [RAW-1:0] rd;
        logic [W-1:0]   data;
    } rec_t;
    rec_t q[$];
    int   e = 0;

    function automatic bit m_busy(input logic [RAW-1:0] r);
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction
    function automatic bit m_we();
        foreach (q[i]) if (q[i].n + S - 1 == e) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [RAW-1:0] m_reg();
        foreach (q[i]) if (q[i].n + S - 1 == e) return q[i].rd;
        return '0;
    endfunction
    function automatic logic [W-1:0] m_data();
        foreach (q[i]) if (q[i].n + S - 1 == e) return q[i].data;
        return '0;
    endfunction

    task automatic step();
        bit           acc;
        rec_t         r;
        acc    = bus4.issue_valid && !bus4.flush && !m_busy(bus4.issue_rd);
        r.rd   = bus4.issue_rd;
        r.data = bus4.issue_a * bus4.issue_b;
        @(posedge clock);
        e++;
        if (bus4.flush) q.delete();
        else if (acc) begin
            r.n = e;
            q.push_back(r);
        end
        while (q.size() > 0 && q[0].n + S <= e) void'(q.pop_front());
        @(negedge clock);
    endtask

    task automatic test_reset();
        #12;
        bus4.issue_rd = 5'd6; bus4.hazard_rs_a = 5'd6; bus4.hazard_rs_b = 5'd0;
        #1;
        total++;
        if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !== '0) begin
            bad++; $display("FAIL reset_port got %b/%0d/%h want 0/0/0",
                bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul);
        end
        total++;
        if (bus4.issue_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got %b want 1", bus4.issue_ready);
        end
        total++;
        if ({bus4.hazard_a, bus4.hazard_b} !== 2'b00) begin
            bad++; $display("FAIL reset_hazard got %b%b want 00", bus4.hazard_a, bus4.hazard_b);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single_op();
        bus4.issue_valid = 1'b1; bus4.issue_rd = 5'd5;
        bus4.issue_a = 32'd7; bus4.issue_b = 32'd6; bus4.hazard_rs_a = 5'd5;
        #1;
        total++;
        if (bus4.issue_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready got %b want 1", bus4.issue_ready);
        end
        step();
        bus4.issue_valid = 1'b0;
        for (int c = 0; c < S + 2; c++) begin
            #1;
            total++;
            if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !==
                {m_we(), m_reg(), m_data()}) begin
                bad++; $display("FAIL single_port c=%0d got %b/%0d/%0d want %b/%0d/%0d", c,
                    bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul,
                    m_we(), m_reg(), m_data());
            end
            total++;
            if (bus4.hazard_a !== m_busy(5'd5)) begin
                bad++; $display("FAIL single_hazard c=%0d got %b want %b", c, bus4.hazard_a, m_busy(5'd5));
            end
            if (c == S - 1) begin
                total++;
                if (bus4.write_data_mul !== 32'd42) begin
                    bad++; $display("FAIL single_data got %0d want 42", bus4.write_data_mul);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            bus4.issue_valid = 1'b1; bus4.issue_rd = RAW'(i);
            bus4.issue_a = 32'hFFFF_FFFF; bus4.issue_b = 32'd2;
            #1;
            total++;
            if (bus4.issue_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready rd=%0d got %b want 1", i, bus4.issue_ready);
            end
            step();
        end
        bus4.issue_valid = 1'b0;
        for (int c = 0; c < S + 3; c++) begin
            total++;
            if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !==
                {m_we(), m_reg(), m_data()}) begin
                bad++; $display("FAIL b2b_port c=%0d got %b/%0d/%h want %b/%0d/%h", c,
                    bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul,
                    m_we(), m_reg(), m_data());
            end
            step();
        end
    endtask

    task automatic test_waw_stall();
        int waited;
        bit got;
        bus4.issue_valid = 1'b1; bus4.issue_rd = 5'd3;
        bus4.issue_a = $urandom; bus4.issue_b = $urandom;
        step();
        bus4.issue_a = $urandom; bus4.issue_b = $urandom;
        waited = 0; got = 1'b0;
        while (!got && waited < 12) begin
            #1;
            total++;
            if (bus4.issue_ready !== !m_busy(5'd3)) begin
                bad++; $display("FAIL waw_ready w=%0d got %b want %b", waited, bus4.issue_ready, !m_busy(5'd3));
            end
            total++;
            if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !==
                {m_we(), m_reg(), m_data()}) begin
                bad++; $display("FAIL waw_port w=%0d got %b/%0d/%h want %b/%0d/%h", waited,
                    bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul,
                    m_we(), m_reg(), m_data());
            end
            got = !m_busy(5'd3);
            step();
            waited++;
        end
        bus4.issue_valid = 1'b0;
        total++;
        if (waited != S + 1) begin
            bad++; $display("FAIL waw_wait got %0d cycles want %0d", waited, S + 1);
        end
        for (int c = 0; c < S + 1; c++) begin
            total++;
            if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !==
                {m_we(), m_reg(), m_data()}) begin
                bad++; $display("FAIL waw_drain c=%0d got %b/%0d/%h want %b/%0d/%h", c,
                    bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul,
                    m_we(), m_reg(), m_data());
            end
            step();
        end
    endtask

    task automatic test_flush();
        logic [RAW-1:0] rds [3];
        rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd9;
        for (int i = 0; i < 3; i++) begin
            bus4.issue_valid = 1'b1; bus4.issue_rd = rds[i];
            bus4.issue_a = $urandom; bus4.issue_b = $urandom;
            step();
        end
        bus4.issue_valid = 1'b0;
        step();
        total++;
        if (bus4.write_enable_mul !== 1'b1 || bus4.write_reg_mul !== 5'd1) begin
            bad++; $display("FAIL flush_r1_port got %b/%0d want 1/1", bus4.write_enable_mul, bus4.write_reg_mul);
        end
        bus4.flush = 1'b1; bus4.issue_valid = 1'b1; bus4.issue_rd = 5'd12;
        #1;
        total++;
        if (bus4.issue_ready !== 1'b0) begin
            bad++; $display("FAIL flush_ready got %b want 0", bus4.issue_ready);
        end
        step();
        bus4.flush = 1'b0; bus4.issue_valid = 1'b0;
        bus4.hazard_rs_a = 5'd2; bus4.hazard_rs_b = 5'd9;
        #1;
        total++;
        if ({bus4.hazard_a, bus4.hazard_b} !== 2'b00) begin
            bad++; $display("FAIL flush_hazard got %b%b want 00", bus4.hazard_a, bus4.hazard_b);
        end
        for (int c = 0; c < S + 1; c++) begin
            total++;
            if (bus4.write_enable_mul !== 1'b0) begin
                bad++; $display("FAIL flush_port c=%0d got we=%b rd=%0d want 0", c,
                    bus4.write_enable_mul, bus4.write_reg_mul);
            end
            step();
        end
    endtask

    task automatic test_reset_midop();
        bus4.issue_valid = 1'b1; bus4.issue_rd = 5'd7;
        bus4.issue_a = $urandom; bus4.issue_b = $urandom; bus4.hazard_rs_a = 5'd7;
        step();
        bus4.issue_valid = 1'b0;
        step();
        reset = 1'b0;
        q.delete();
        #1;
        total++;
        if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul, bus4.hazard_a} !== '0) begin
            bad++; $display("FAIL midreset_outputs got %b/%0d/%h hz=%b want all 0",
                bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul, bus4.hazard_a);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus4.issue_valid = 1'b1; bus4.issue_a = $urandom; bus4.issue_b = $urandom;
        #1;
        total++;
        if (bus4.issue_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got %b want 1", bus4.issue_ready);
        end
        step();
        bus4.issue_valid = 1'b0;
        for (int c = 0; c < S + 1; c++) begin
            total++;
            if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !==
                {m_we(), m_reg(), m_data()}) begin
                bad++; $display("FAIL midreset_port c=%0d got %b/%0d/%h want %b/%0d/%h", c,
                    bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul,
                    m_we(), m_reg(), m_data());
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            bus4.issue_valid = ($urandom % 4) != 0;
            bus4.issue_rd    = RAW'($urandom % 8);
            bus4.issue_a     = $urandom;
            bus4.issue_b     = $urandom;
            bus4.flush       = ($urandom % 20) == 0;
            bus4.hazard_rs_a = RAW'($urandom % 8);
            bus4.hazard_rs_b = RAW'($urandom % 8);
            #1;
            total++;
            if (bus4.issue_ready !== (!bus4.flush && !m_busy(bus4.issue_rd))) begin
                bad++; $display("FAIL rand_ready c=%0d got %b want %b", c, bus4.issue_ready,
                    !bus4.flush && !m_busy(bus4.issue_rd));
            end
            total++;
            if ({bus4.hazard_a, bus4.hazard_b} !== {m_busy(bus4.hazard_rs_a), m_busy(bus4.hazard_rs_b)}) begin
                bad++; $display("FAIL rand_hazard c=%0d got %b%b want %b%b", c, bus4.hazard_a,
                    bus4.hazard_b, m_busy(bus4.hazard_rs_a), m_busy(bus4.hazard_rs_b));
            end
            total++;
            if ({bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul} !==
                {m_we(), m_reg(), m_data()}) begin
                bad++; $display("FAIL rand_port c=%0d got %b/%0d/%h want %b/%0d/%h", c,
                    bus4.write_enable_mul, bus4.write_reg_mul, bus4.write_data_mul,
                    m_we(), m_reg(), m_data());
            end
            step();
        end
        bus4.issue_valid = 1'b0;
        bus4.flush       = 1'b0;
        repeat (S + 1) step();
    endtask

    task automatic test_single_stage();
        logic [W-1:0] a, b;
        a = 32'd3; b = 32'd5;
        for (int k = 0; k < 4; k++) begin
            bus1.issue_valid = 1'b1; bus1.issue_rd = 5'd2;
            bus1.issue_a = a; bus1.issue_b = b;
            #1;
            total++;
            if (bus1.issue_ready !== 1'b1) begin
                bad++; $display("FAIL s1_ready k=%0d got %b want 1", k, bus1.issue_ready);
            end
            @(posedge clock);
            @(negedge clock);
            total++;
            if ({bus1.write_enable_mul, bus1.write_reg_mul, bus1.write_data_mul} !==
                {1'b1, 5'd2, W'(a * b)}) begin
                bad++; $display("FAIL s1_port k=%0d got %b/%0d/%0d want 1/2/%0d", k,
                    bus1.write_enable_mul, bus1.write_reg_mul, bus1.write_data_mul, W'(a * b));
            end
            total++;
            if (bus1.issue_ready !== 1'b0) begin
                bad++; $display("FAIL s1_stall k=%0d got %b want 0", k, bus1.issue_ready);
            end
            @(posedge clock);
            @(negedge clock);
            total++;
            if (bus1.write_enable_mul !== 1'b0) begin
                bad++; $display("FAIL s1_idle k=%0d got %b want 0", k, bus1.write_enable_mul);
            end
            a = $urandom; b = $urandom;
        end
        bus1.issue_valid = 1'b0;
    endtask

    initial begin
        bus4.issue_valid = 1'b0; bus4.issue_rd = '0; bus4.issue_a = '0; bus4.issue_b = '0;
        bus4.flush = 1'b0; bus4.hazard_rs_a = '0; bus4.hazard_rs_b = '0;
        bus1.issue_valid = 1'b0; bus1.issue_rd = '0; bus1.issue_a = '0; bus1.issue_b = '0;
        bus1.flush = 1'b0; bus1.hazard_rs_a = '0; bus1.hazard_rs_b = '0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_waw_stall();
        test_flush();
        test_reset_midop();
        test_random();
        test_single_stage();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
